// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch and sequencing for the single-cycle datapath. Owns the
//   PC, fetches one word per instruction over a req/ack handshake, presents
//   it for exactly one execute cycle and computes the next PC from the
//   control strobes and the datapath flags. A halt opcode or a memory that
//   never acknowledges parks the unit until reset.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request (FETCH only) and its address (= pc)
//   imem_rdata/imem_ack returned instruction word and its strobe
//   inst, inst_valid    registered instruction; valid pulse in EXEC only
//   beq/bne/bgtz/jump   control-unit branch/jump strobes for inst
//   zero, msb           datapath ALU flags for inst
//   pc                  current program counter
//   halted, fault       sticky status (HALT or FAULT / FAULT only)
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h00400020,
    parameter logic [5:0]  HALT_OP     = 6'b111111,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        beq,
    input  logic        bne,
    input  logic        bgtz,
    input  logic        jump,
    input  logic        zero,
    input  logic        msb,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Last counter value tolerated without an ack; reaching it with ack still
    // low means ACK_TIMEOUT FETCH cycles have elapsed.
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [31:0] p4_s;
    logic [31:0] br_tgt_s;
    logic [31:0] jmp_tgt_s;
    logic [31:0] next_pc_s;

    // Next-PC selection: jump > beq > bne > bgtz; a strobe whose condition
    // is false falls through to the next candidate.
    always_comb begin
        p4_s      = pc_r + 32'd4;
        br_tgt_s  = p4_s + {{14{inst_r[15]}}, inst_r[15:0], 2'b00};
        jmp_tgt_s = {p4_s[31:28], inst_r[25:0], 2'b00};
        if (jump) begin
            next_pc_s = jmp_tgt_s;
        end else if (beq && zero) begin
            next_pc_s = br_tgt_s;
        end else if (bne && !zero) begin
            next_pc_s = br_tgt_s;
        end else if (bgtz && !zero && !msb) begin
            next_pc_s = br_tgt_s;
        end else begin
            next_pc_s = p4_s;
        end
    end

    // Sequencer next-state: fetch/wait-count, execute, and the parked states.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_s = imem_rdata;
                    cnt_s  = 8'd0;
                    if (imem_rdata[31:26] == HALT_OP) begin
                        state_s = ST_HALT;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_FAULT;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_EXEC: begin
                pc_s    = next_pc_s;
                state_s = ST_FETCH;
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
            default: begin
                state_s = ST_FAULT;
            end
        endcase
    end

    // State, PC, instruction and wait-counter registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            inst_r  <= 32'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            inst_r  <= inst_s;
            cnt_r   <= cnt_s;
        end
    end

    // Status outputs are straight decodes of the state register, so they are
    // glitch-free and change only at the clock edge.
    assign imem_req   = (state_r == ST_FETCH);
    assign inst_valid = (state_r == ST_EXEC);
    assign halted     = (state_r == ST_HALT) || (state_r == ST_FAULT);
    assign fault      = (state_r == ST_FAULT);
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign inst       = inst_r;

endmodule
